// File: rtl/fxp_pkg.sv
// fxp_pkg: Q8.24 fixed-point constants, backprop FSM states and saturating subtract
package fxp_pkg;
  localparam int WIDTH = 32;
  localparam int FRAC = 24;
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, SCALE, UPD, PROP, DONE} state_t;
  function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] d;
    d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    return (d[WIDTH] != d[WIDTH-1]) ? (d[WIDTH] ? SAT_MIN : SAT_MAX) : d[WIDTH-1:0];
  endfunction
endpackage

// File: rtl/fxp_mul.sv
// fxp_mul: signed fixed-point multiply, floor shift by FRAC, saturate to WIDTH
module fxp_mul #(
  parameter int WIDTH = 32,
  parameter int FRAC = 24
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);
  logic signed [2*WIDTH-1:0] full, sh;
  logic fits;
  assign full = a * b;
  assign sh = full >>> FRAC;
  // the result fits when every bit above the kept word matches its sign bit
  assign fits = &sh[2*WIDTH-1:WIDTH-1] | ~|sh[2*WIDTH-1:WIDTH-1];
  assign p = fits ? sh[WIDTH-1:0] : sh[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
endmodule

// File: rtl/perceptron_bp.sv
// perceptron_bp: one-neuron backward pass (SGD update + error propagation) on a shared multiplier
module perceptron_bp
  import fxp_pkg::*;
#(
  parameter int NUM = 2,
  parameter int WIDTH = fxp_pkg::WIDTH,
  parameter int FRAC = fxp_pkg::FRAC
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NUM*WIDTH-1:0] i_k,
  input  logic [NUM*WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [WIDTH-1:0]     i_delta,
  input  logic [WIDTH-1:0]     i_lr,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NUM*WIDTH-1:0] o_w,
  output logic [WIDTH-1:0]     o_b,
  output logic [NUM*WIDTH-1:0] o_dk
);
  localparam int IW = NUM > 1 ? $clog2(NUM) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM - 1);
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic signed [WIDTH-1:0] k_r [NUM];
  logic signed [WIDTH-1:0] w_r [NUM];
  logic signed [WIDTH-1:0] w_o [NUM];
  logic signed [WIDTH-1:0] dk_o [NUM];
  logic signed [WIDTH-1:0] b_r, delta_r, lr_r, ld, mul_a, mul_b, prod;
  logic accept;
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
  assign accept = i_valid && o_ready;
  // SCALE forms lr*delta, UPD scales the input by it, PROP uses the pre-update weight
  assign mul_a = state == SCALE ? lr_r : state == UPD ? ld : delta_r;
  assign mul_b = state == SCALE ? delta_r : state == UPD ? k_r[idx] : w_r[idx];
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (.a(mul_a), .b(mul_b), .p(prod));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? SCALE : IDLE;
      SCALE:   state_nx = UPD;
      UPD:     state_nx = PROP;
      PROP:    state_nx = idx == LAST ? DONE : UPD;
      DONE:    state_nx = i_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      idx <= '0;
      b_r <= '0;
      delta_r <= '0;
      lr_r <= '0;
      ld <= '0;
      o_b <= '0;
      for (int n = 0; n < NUM; n++) begin
        k_r[n] <= '0;
        w_r[n] <= '0;
        w_o[n] <= '0;
        dk_o[n] <= '0;
      end
    end else begin
      state <= state_nx;
      if (accept) begin
        for (int n = 0; n < NUM; n++) begin
          k_r[n] <= i_k[n*WIDTH +: WIDTH];
          w_r[n] <= i_w[n*WIDTH +: WIDTH];
        end
        b_r <= i_b;
        delta_r <= i_delta;
        lr_r <= i_lr;
      end
      if (state == SCALE) begin
        ld <= prod;
        o_b <= sat_sub(b_r, prod);
      end
      if (state == UPD) w_o[idx] <= sat_sub(w_r[idx], prod);
      if (state == PROP) begin
        dk_o[idx] <= prod;
        idx <= idx == LAST ? '0 : idx + IW'(1);
      end
    end
  end
  for (genvar n = 0; n < NUM; n++) begin : g_out
    assign o_w[n*WIDTH +: WIDTH] = w_o[n];
    assign o_dk[n*WIDTH +: WIDTH] = dk_o[n];
  end
endmodule

// File: tb/tb_perceptron_bp.sv
// tb_perceptron_bp: randomized scoreboard bench for perceptron_bp against an arithmetic model
module tb_perceptron_bp;
  localparam int NUM = 2;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, i_valid = 0, i_ready = 1, o_ready, o_valid;
  logic [NUM*W-1:0] i_k = '0, i_w = '0, o_w, o_dk;
  logic [W-1:0] i_b = '0, i_delta = '0, i_lr = '0, o_b;
  int passed = 0, total = 0, cyc = 0;
  logic btb = 0, have_prev = 0, vprev = 0;
  int prev_acc = 0;
  logic [NUM*W-1:0] last_w, last_dk;
  logic [W-1:0] last_b;
  typedef struct packed {
    logic [NUM-1:0][31:0] w;
    logic [NUM-1:0][31:0] dk;
    logic [31:0] b;
    int acc;
  } exp_t;
  exp_t sb [$];
  exp_t e_in, e_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  perceptron_bp #(.NUM(NUM)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_k(i_k), .i_w(i_w), .i_b(i_b), .i_delta(i_delta), .i_lr(i_lr),
    .o_valid(o_valid), .i_ready(i_ready), .o_w(o_w), .o_b(o_b), .o_dk(o_dk)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] sat(longint v);
    if (v > 64'sd2147483647) return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
    return 32'(v);
  endfunction

  // real-valued product a*b/2^24 rounded toward minus infinity, then clamped
  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    longint p, q;
    p = longint'($signed(a)) * longint'($signed(b));
    q = p / 64'sd16777216;
    if (p < 0 && (p % 64'sd16777216) != 0) q = q - 1;
    return sat(q);
  endfunction

  function automatic logic [31:0] fsub(logic [31:0] a, logic [31:0] b);
    return sat(longint'($signed(a)) - longint'($signed(b)));
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // input side: a job is taken at the next rising edge
  always @(negedge clk) begin
    if (rst_n && i_valid && o_ready) begin
      logic [31:0] ld;
      ld = fmul(i_lr, i_delta);
      e_in.b = fsub(i_b, ld);
      for (int n = 0; n < NUM; n++) begin
        e_in.w[n] = fsub(i_w[n*W +: W], fmul(ld, i_k[n*W +: W]));
        e_in.dk[n] = fmul(i_delta, i_w[n*W +: W]);
      end
      e_in.acc = cyc + 1;
      sb.push_back(e_in);
      if (btb && have_prev) check("period", 32'(e_in.acc - prev_acc), 32'(2*NUM+3));
      prev_acc = e_in.acc;
      have_prev = 1;
    end
  end

  // output side
  always @(negedge clk) begin
    if (o_valid && !vprev && sb.size() > 0) check("latency", 32'(cyc - sb[0].acc), 32'(2*NUM+1));
    vprev = o_valid;
    if (o_valid && i_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got o_b=%h expected no result", o_b);
      end else begin
        e_out = sb.pop_front();
        check("o_b", o_b, e_out.b);
        for (int n = 0; n < NUM; n++) begin
          check($sformatf("o_w%0d", n), o_w[n*W +: W], e_out.w[n]);
          check($sformatf("o_dk%0d", n), o_dk[n*W +: W], e_out.dk[n]);
        end
        last_w = o_w;
        last_dk = o_dk;
        last_b = o_b;
      end
    end
  end

  task automatic send(logic [NUM*W-1:0] k, logic [NUM*W-1:0] w, logic [W-1:0] b, logic [W-1:0] d, logic [W-1:0] lr);
    int t = 0;
    i_k = k; i_w = w; i_b = b; i_delta = d; i_lr = lr; i_valid = 1;
    do begin
      @(negedge clk);
      t++;
    end while (!o_ready && t < 200);
    if (!o_ready) begin
      total++;
      $display("FAIL accept_timeout: got o_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    i_valid = 0;
    i_k = rnd64(); i_w = rnd64(); i_b = $urandom; i_delta = $urandom; i_lr = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    logic [NUM*W-1:0] hw, hdk;
    logic [W-1:0] hb;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 1);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_w0", o_w[31:0], 0);
    check("rst_w1", o_w[63:32], 0);
    check("rst_dk0", o_dk[31:0], 0);
    check("rst_b", o_b, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    // directed example
    send({$urandom, 32'h02000000}, {$urandom, 32'h01000000}, 32'h00400000, 32'h01000000, 32'h00800000);
    drain();
    check("ex_w0", last_w[31:0], 32'h00000000);
    check("ex_dk0", last_dk[31:0], 32'h01000000);
    check("ex_b", last_b, 32'hFFC00000);
    // zero learning rate leaves weights and bias untouched
    repeat (50) send(rnd64(), rnd64(), $urandom, $urandom, 32'h0);
    drain();
    // propagated-error saturation
    send(rnd64(), {32'h02000000, $urandom}, $urandom, 32'h7F000000, $urandom);
    drain();
    check("sat_pos_dk1", last_dk[63:32], 32'h7FFFFFFF);
    send(rnd64(), {32'hFE000000, $urandom}, $urandom, 32'h7F000000, $urandom);
    drain();
    check("sat_neg_dk1", last_dk[63:32], 32'h80000000);
    // consumer stall in DONE, new jobs offered meanwhile
    i_ready = 0;
    send(rnd64(), rnd64(), $urandom, $urandom, $urandom >> 8);
    repeat (5) @(posedge clk);
    #1;
    check("hold_valid", 32'(o_valid), 1);
    hw = o_w; hdk = o_dk; hb = o_b;
    for (int i = 0; i < 10; i++) begin
      i_valid = ~i_valid;
      i_k = rnd64(); i_w = rnd64(); i_b = $urandom; i_delta = $urandom; i_lr = $urandom;
      @(posedge clk);
      #1;
      check("hold_valid", 32'(o_valid), 1);
      check("hold_ready", 32'(o_ready), 0);
      check("hold_w1", o_w[63:32], hw[63:32]);
      check("hold_dk0", o_dk[31:0], hdk[31:0]);
      check("hold_b", o_b, hb);
    end
    i_valid = 0;
    i_ready = 1;
    @(posedge clk);
    #1;
    check("release_ready", 32'(o_ready), 1);
    check("release_valid", 32'(o_valid), 0);
    check("release_pending", 32'(sb.size()), 0);
    send(rnd64(), rnd64(), $urandom, $urandom, $urandom >> 4);
    drain();
    // asynchronous reset during PROP(0)
    send(rnd64(), rnd64(), $urandom, $urandom, $urandom);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 0;
    #1;
    check("abort_valid", 32'(o_valid), 0);
    check("abort_ready", 32'(o_ready), 1);
    check("abort_w0", o_w[31:0], 0);
    check("abort_dk1", o_dk[63:32], 0);
    check("abort_b", o_b, 0);
    sb.delete();
    vprev = 0;
    #2;
    rst_n = 1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_valid", 32'(o_valid), 0);
    // back-to-back jobs at full rate
    btb = 1;
    have_prev = 0;
    repeat (12) send(rnd64(), rnd64(), $urandom, $urandom, $urandom >> ($urandom_range(0, 12)));
    drain();
    btb = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
